ir_prefetch_decoder: RTL and testbench
======================================

# ir_prefetch_decoder

Instruction register with a parametrised prefetch queue for the multicycle CPU. Fetched instruction words are pushed into a DEPTH-entry FIFO with a valid/ready handshake. The control FSM's IR-write strobe pops the oldest word into the instruction register, which drives decoded MIPS fields until the next load. It replaces the single-register decoder and decouples memory fetch timing from the control FSM.

## Interface
- DATA_W, 32, instruction word width; must be 32 for MIPS field positions
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), width of `count`
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch word present on `in_ins`
- in_ins  in  DATA_W  fetched instruction word
- in_ready  out  1  queue can accept; equals !full
- IRWrite  in  1  load IR from queue head (pop)
- flush  in  1  discard queue and invalidate IR (branch/jump taken)
- dec_valid  out  1  IR holds a valid instruction
- FullIns  out  DATA_W  raw IR contents
- OPcode  out  6  IR[31:26]
- Rs  out  5  IR[25:21]
- Rt  out  5  IR[20:16]
- Rd  out  5  IR[15:11]
- shamt  out  5  IR[10:6]
- funct  out  6  IR[5:0]
- imm  out  16  IR[15:0]
- imm_sext  out  32  imm sign-extended
- jaddr  out  26  IR[25:0]
- r_type / i_type / j_type  out  1 each  one-hot class: OPcode==0 / other / OPcode∈{2,3}
- count  out  CNT_W  queue occupancy, 0..DEPTH

## Operation
- Queue: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, plus occupancy counter.
- push = in_valid && in_ready. pop = IRWrite && (count != 0).
- On pop: IR <= queue head, dec_valid <= 1.
- IRWrite with empty queue: IR holds its previous value, dec_valid <= 0 (bubble).
- IRWrite=0: IR and dec_valid hold; all decode outputs stable.
- Full queue: in_ready=0; a push is refused even if pop occurs in the same cycle (no full-pass-through).
- Empty queue with simultaneous push and IRWrite: push is stored, no bypass; IR gets bubble (dec_valid <= 0), new word reaches IR on the next IRWrite.
- Simultaneous push and pop when 0<count<DEPTH: both occur, count unchanged.
- flush has highest priority: count, pointers <= 0, dec_valid <= 0, IR holds value; any push/pop that cycle is ignored.
- All decode outputs are purely combinational from IR; class outputs are combinational from OPcode and exactly one is 1, even when dec_valid=0.
- Reset (async, any time, including mid-transfer): IR=0, dec_valid=0, count=0, pointers=0, in_ready=1. Hence OPcode=0, r_type=1, all other fields 0. Storage contents are don't-care.

## Timing
- Push-to-IR latency: minimum 2 edges (store at edge N, pop via IRWrite at edge N+1 earliest).
- IRWrite to decoded fields: visible after the same rising edge, no extra latency.
- in_ready and count are registered-state derived, updated one edge after push/pop/flush.
- Sustained throughput: one instruction per cycle with in_valid and IRWrite both held high and count≥1.
- Reset release is synchronised by the system; block samples inputs from the first rising edge with rst_n=1.

## Test plan
- Reset: drive rst_n=0 mid-run with count=3 -> immediately FullIns=0, dec_valid=0, count=0, in_ready=1, r_type=1.
- Push 32'hFFFFFFFF, 32'hABCDEF12, then IRWrite twice -> IR=FFFFFFFF (OPcode=3F, imm_sext=FFFFFFFF, i_type=1), then IR=ABCDEF12 (OPcode=2A, Rs=1E, Rt=0D, Rd=1D, shamt=1C, funct=12, imm_sext=FFFFEF12).
- Fill: push DEPTH words with IRWrite=0 -> count=DEPTH, in_ready=0; further in_valid ignored; IRWrite=0 with new in_ins=32'h11111111 leaves IR unchanged.
- Wrap: 3×DEPTH pushes interleaved with pops, simultaneous push/pop at count=2 -> FIFO order preserved across pointer wrap, count stays 2.
- Empty IRWrite: IRWrite with count=0 -> dec_valid=0, FullIns unchanged; same cycle push 32'h08000010 -> count=1, next IRWrite gives j_type=1, jaddr=0000010.
- Flush: count=3, flush with in_valid and IRWrite high -> count=0, dec_valid=0, pushed word discarded, IR unchanged.

Source files
------------

// File: rtl/ir_prefetch_decoder.sv
// ir_prefetch_decoder
//   Instruction register fed by a DEPTH-entry prefetch FIFO. Fetched words
//   enter through a valid/ready handshake; the control FSM's IRWrite strobe
//   pops the oldest word into the IR, which drives the decoded MIPS fields
//   until the next load.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ins     fetched instruction word and its valid flag
//   in_ready             queue can accept a word (not full)
//   IRWrite              load IR from queue head; bubble if queue empty
//   flush                discard queue contents and invalidate IR
//   dec_valid            IR holds a valid instruction
//   FullIns              raw IR contents
//   OPcode..jaddr        decoded fields of IR
//   imm_sext             imm sign-extended to 32 bits
//   r_type/i_type/j_type one-hot instruction class from OPcode
//   count                queue occupancy, 0..DEPTH
module ir_prefetch_decoder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_ins,
    output logic              in_ready,
    input  logic              IRWrite,
    input  logic              flush,
    output logic              dec_valid,
    output logic [DATA_W-1:0] FullIns,
    output logic [5:0]        OPcode,
    output logic [4:0]        Rs,
    output logic [4:0]        Rt,
    output logic [4:0]        Rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [31:0]       imm_sext,
    output logic [25:0]       jaddr,
    output logic              r_type,
    output logic              i_type,
    output logic              j_type,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] ir;
    logic              push;
    logic              pop;

    // in_ready comes from registered occupancy only, so a full queue refuses
    // a push even while it is being popped in the same cycle.
    assign in_ready = (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign pop      = IRWrite && (count != '0) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ir        <= '0;
            dec_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dec_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Empty-queue IRWrite inserts a bubble: IR keeps its value.
            if (pop) begin
                ir        <= mem[rd_ptr];
                dec_valid <= 1'b1;
            end else if (IRWrite) begin
                dec_valid <= 1'b0;
            end
        end
    end

    // Storage contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_ins;
    end

    always_comb begin
        FullIns  = ir;
        OPcode   = ir[31:26];
        Rs       = ir[25:21];
        Rt       = ir[20:16];
        Rd       = ir[15:11];
        shamt    = ir[10:6];
        funct    = ir[5:0];
        imm      = ir[15:0];
        imm_sext = {{16{ir[15]}}, ir[15:0]};
        jaddr    = ir[25:0];
        r_type   = (ir[31:26] == 6'd0);
        j_type   = (ir[31:26] == 6'd2) || (ir[31:26] == 6'd3);
        i_type   = !r_type && !j_type;
    end

endmodule

// File: tb/tb_ir_prefetch_decoder.sv
module tb_ir_prefetch_decoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [31:0]       in_ins;
    logic              in_ready;
    logic              IRWrite;
    logic              flush;
    logic              dec_valid;
    logic [31:0]       FullIns;
    logic [5:0]        OPcode;
    logic [4:0]        Rs, Rt, Rd, shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [31:0]       imm_sext;
    logic [25:0]       jaddr;
    logic              r_type, i_type, j_type;
    logic [CNT_W-1:0]  count;

    ir_prefetch_decoder #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ins(in_ins),
        .in_ready(in_ready), .IRWrite(IRWrite), .flush(flush),
        .dec_valid(dec_valid), .FullIns(FullIns), .OPcode(OPcode),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .shamt(shamt), .funct(funct),
        .imm(imm), .imm_sext(imm_sext), .jaddr(jaddr),
        .r_type(r_type), .i_type(i_type), .j_type(j_type), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending words plus the IR and its valid bit.
    logic [31:0] mq[$];
    logic [31:0] m_ir;
    bit          m_dv;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        int unsigned op, s;
        logic [31:0] sx;
        op = (m_ir >> 26) & 32'h3F;
        s  = m_ir & 32'hFFFF;
        sx = (s >= 32768) ? (s + 32'hFFFF0000) : s;
        chk("FullIns",   FullIns,   m_ir);
        chk("dec_valid", 32'(dec_valid), 32'(m_dv));
        chk("count",     32'(count),     mq.size());
        chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
        chk("OPcode",    32'(OPcode),    op);
        chk("Rs",        32'(Rs),        (m_ir >> 21) & 32'h1F);
        chk("Rt",        32'(Rt),        (m_ir >> 16) & 32'h1F);
        chk("Rd",        32'(Rd),        (m_ir >> 11) & 32'h1F);
        chk("shamt",     32'(shamt),     (m_ir >> 6) & 32'h1F);
        chk("funct",     32'(funct),     m_ir & 32'h3F);
        chk("imm",       32'(imm),       s);
        chk("imm_sext",  imm_sext,       sx);
        chk("jaddr",     32'(jaddr),     m_ir & 32'h3FFFFFF);
        chk("r_type",    32'(r_type),    32'(op == 0));
        chk("j_type",    32'(j_type),    32'(op == 2 || op == 3));
        chk("i_type",    32'(i_type),    32'(op != 0 && op != 2 && op != 3));
    endtask

    // Called #1 after a rising edge: apply inputs, advance one edge, check.
    task automatic cyc(input bit v, input logic [31:0] ins, input bit irw, input bit fl);
        bit do_push, do_pop;
        in_valid = v; in_ins = ins; IRWrite = irw; flush = fl;
        do_push = v && (mq.size() < DEPTH);
        do_pop  = irw && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            m_dv = 0;
        end else begin
            if (do_pop) begin
                m_ir = mq.pop_front();
                m_dv = 1;
            end else if (irw) begin
                m_dv = 0;
            end
            if (do_push) mq.push_back(ins);
        end
        check_all();
    endtask

    task automatic model_reset();
        mq.delete();
        m_ir = '0;
        m_dv = 0;
    endtask

    initial begin
        logic [31:0] ir_before;
        rst_n = 1'b0; in_valid = 0; in_ins = '0; IRWrite = 0; flush = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed decode of two known words.
        cyc(1, 32'hFFFFFFFF, 0, 0);
        cyc(1, 32'hABCDEF12, 0, 0);
        cyc(0, 32'h0, 1, 0);
        chk("ffff_i_type", 32'(i_type), 32'd1);
        chk("ffff_sext",   imm_sext,    32'hFFFFFFFF);
        cyc(0, 32'h0, 1, 0);
        chk("abcd_op",   32'(OPcode), 32'h2A);
        chk("abcd_rs",   32'(Rs),     32'h1E);
        chk("abcd_rd",   32'(Rd),     32'h1D);
        chk("abcd_sext", imm_sext,    32'hFFFFEF12);

        // Fill, then attempt extra pushes and a held IR.
        for (int i = 0; i < DEPTH; i++) cyc(1, $urandom, 0, 0);
        chk("full_ready", 32'(in_ready), 32'd0);
        cyc(1, 32'hDEADBEEF, 0, 0);
        cyc(1, 32'h11111111, 0, 0);
        chk("full_count", 32'(count), DEPTH);
        // Full queue with pop: the simultaneous push must be refused.
        cyc(1, 32'h22222222, 1, 0);
        while (mq.size() > 0) cyc(0, 32'h0, 1, 0);

        // Wrap: hold occupancy at 2 with simultaneous push/pop.
        cyc(1, $urandom, 0, 0);
        cyc(1, $urandom, 0, 0);
        for (int i = 0; i < 3 * DEPTH; i++) cyc(1, $urandom, 1, 0);
        chk("wrap_count", 32'(count), 32'd2);
        while (mq.size() > 0) cyc(0, 32'h0, 1, 0);

        // Empty IRWrite with simultaneous push: bubble, no bypass.
        ir_before = m_ir;
        cyc(1, 32'h08000010, 1, 0);
        chk("bubble_dv",  32'(dec_valid), 32'd0);
        chk("bubble_ir",  FullIns,        ir_before);
        chk("bubble_cnt", 32'(count),     32'd1);
        cyc(0, 32'h0, 1, 0);
        chk("j_type",  32'(j_type), 32'd1);
        chk("jaddr",   32'(jaddr),  32'h0000010);

        // Flush beats push and pop in the same cycle.
        for (int i = 0; i < 3; i++) cyc(1, $urandom, 0, 0);
        ir_before = m_ir;
        cyc(1, 32'h12345678, 1, 1);
        chk("flush_cnt", 32'(count),     32'd0);
        chk("flush_dv",  32'(dec_valid), 32'd0);
        chk("flush_ir",  FullIns,        ir_before);
        cyc(0, 32'h0, 1, 0);

        // Randomised traffic with occasional flushes and opcode bias toward
        // the class boundaries.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[31:26] = 6'($urandom_range(0, 4));
            cyc(bit'($urandom_range(0, 1)), w, bit'($urandom_range(0, 2) != 0),
                $urandom_range(0, 30) == 0);
        end

        // Asynchronous reset mid-cycle with three words queued.
        while (mq.size() > 0) cyc(0, 32'h0, 1, 0);
        cyc(1, 32'hABCDEF12, 0, 0);
        cyc(0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, $urandom, 0, 0);
        chk("pre_rst_cnt", 32'(count), 32'd3);
        in_valid = 1; IRWrite = 1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        in_valid = 0; IRWrite = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_all();
        cyc(1, 32'h0C000001, 0, 0);
        cyc(0, 32'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
